// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and its feeders.
//
// Contents:
//   BYTE_W      - width of one UART character
//   CLK_HZ      - system clock frequency
//   BAUD_RATE   - serial line rate
//   BAUD_DIV    - clocks per bit, rounded to nearest
//   BAUD_HALF   - clocks to the middle of a bit, used by the receiver
//   seq_state_t - launch sequencer states of uart_tx_fifo
package uart_pkg;

    localparam int BYTE_W    = 8;

    localparam int CLK_HZ    = 50_000_000;
    localparam int BAUD_RATE = 115_200;
    localparam int BAUD_DIV  = (CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int BAUD_HALF = BAUD_DIV / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with an explicit occupancy counter.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write request; ignored while full
//   push_data   - data written on an accepted push
//   pop         - read request; ignored while empty
//   pop_data    - entry at the read pointer (valid while !empty)
//   count       - entries held, 0..DEPTH
//   full, empty - decoded from count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty reflect the count at the start of the cycle, so a push
    // into a full FIFO is dropped even if a pop happens in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign pop_data = mem[rd_ptr];

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer between the CPU write port and the
// UART transmitter. Bytes are queued in a sync_fifo and handed to the
// UART one at a time, using busy_flag as the handshake.
//
// Ports:
//   clk, rst_n  - 50 MHz clock, asynchronous active-low reset
//   wr_en       - CPU push strobe, up to one byte per clock
//   wr_data     - byte to push
//   clr_ovf     - clears overflow (a simultaneous dropped push wins)
//   busy_flag   - UART transmitter busy
//   full, empty - FIFO status
//   count       - bytes queued, excluding the byte being transmitted
//   overflow    - sticky: a push was dropped because the FIFO was full
//   tx_en       - high while a byte is being launched/transmitted
//   begin_flag  - one-cycle launch pulse to the UART
//   tx_data     - byte presented to the UART, held until the next load
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BUSY_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [BYTE_W-1:0]       wr_data,
    input  logic                    clr_ovf,
    input  logic                    busy_flag,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    tx_en,
    output logic                    begin_flag,
    output logic [BYTE_W-1:0]       tx_data
);

    localparam int WCW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(BUSY_WAIT - 1);

    seq_state_t        state;
    logic [WCW-1:0]    wait_cnt;
    logic [BYTE_W-1:0] head_data;
    logic              load;

    // A byte is only taken when the UART is idle, so a frame still running
    // after reset or a busy timeout is never overrun.
    assign load = (state == IDLE) && !empty && !busy_flag;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (load),
        .pop_data  (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // tx_en and begin_flag are registered alongside the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_data    <= '0;
            begin_flag <= 1'b0;
            tx_en      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        tx_data    <= head_data;
                        begin_flag <= 1'b1;
                        tx_en      <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    begin_flag <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT_HI;
                end
                WAIT_HI: begin
                    // If the UART never acknowledges, give up after
                    // BUSY_WAIT samples and treat the byte as sent.
                    if (busy_flag) begin
                        state <= WAIT_LO;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= IDLE;
                        tx_en <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!busy_flag) begin
                        state <= IDLE;
                        tx_en <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tx_en      <= 1'b0;
                    begin_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule
